memory_port_arbiter: RTL and testbench
======================================

// Module: memory_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the instruction fetch (IF) and data (MEM stage) requesters.
//  Sits between the pipeline and the MMU backing RAM.
//  Per-requester success pulses feed the stall unit (IF) and the freeze unit (data).
//  Data has priority; a streak limit keeps fetch from starving.
// PARAMETERS
//  DATA_STREAK_MAX  4    consecutive data grants with ifReq pending before IF is forced a grant (>=1)
//  TIMEOUT_CYCLES   256  cycles in BUSY without memReady before abort (only with ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-low reset
//  ifReq          in   1   fetch request; held with ifAddr stable until ifSuccess
//  ifAddr         in   32  fetch address
//  ifSuccess      out  1   one-cycle pulse: fetch complete, ifData valid
//  ifData         out  32  fetched word; registered, held until next IF completion
//  dmReq          in   1   data request (read or write); held stable until dmSuccess
//  dmWrite        in   1   1 = write, 0 = read
//  dmAddr         in   32  data address
//  dmWData        in   32  write data
//  dmByteEnable   in   4   write byte lanes
//  dmSuccess      out  1   one-cycle pulse: data access complete
//  dmRData        out  32  read data; registered, updated only on read completion
//  memReq         out  1   memory request; held until memReady sampled high
//  memWrite       out  1   memory write strobe, qualified by memReq
//  memAddr        out  32  memory address, stable while memReq high
//  memWData       out  32  memory write data
//  memByteEnable  out  4   memory write lanes
//  memReady       in   1   memory handshake: transfer done this cycle; memRData valid if read
//  memRData       in   32  memory read data
//  timeoutError   out  1   sticky abort flag (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; streak = 0.
//   - memReq, memWrite, ifSuccess, dmSuccess, timeoutError = 0.
//   - memAddr, memWData, memByteEnable, ifData, dmRData = 0.
//  FSM: IDLE -> BUSY_D | BUSY_I -> RESP -> IDLE.
//  IDLE arbitration (evaluated only in IDLE):
//   - dmReq && !(ifReq && streak==DATA_STREAK_MAX) -> BUSY_D.
//   - Otherwise ifReq -> BUSY_I.
//   - Neither -> stay IDLE.
//  Streak counter:
//   - Data grant while ifReq=1: streak++, saturating at DATA_STREAK_MAX.
//   - Data grant while ifReq=0: streak = 0.
//   - IF grant: streak = 0.
//  Request registration:
//   - On grant: latch addr, wdata, byte enable, write into mem* regs; memReq=1 from the next cycle.
//   - IF accesses always drive memWrite=0.
//  BUSY_x:
//   - memReq held with all mem* outputs stable.
//   - memReady=1 in the same cycle that memReq is high: drop memReq, capture memRData into ifData
//     (BUSY_I) or into dmRData (BUSY_D read only), go to RESP.
//  RESP: exactly one cycle.
//   - The serving requester's success is asserted; the other success stays 0.
//   - Requester inputs are ignored.
//  Latency: request sampled in IDLE at edge k; memReq high at k+1.
//   - memReady in the first BUSY cycle gives success in cycle k+2.
//   - Next grant at earliest k+3 (IDLE).
//  Throughput: 3 cycles/access minimum. Both success outputs are never high together.
//  Requester dropping its req mid-access:
//   - The access still completes on the memory side; the success pulse still fires.
//   - For a dropped IF access, ifData is updated anyway.
//  Simultaneous requests at streak limit: IF wins once, then data regains priority.
//  Asynchronous reset mid-access: memReq falls immediately; the in-flight access is abandoned
//   with no success pulse. The memory tolerates an abandoned handshake.
//  Address/data are passed unmodified; no alignment checks.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to BUSY_x and increments each BUSY cycle.
//   - Reaching TIMEOUT_CYCLES without memReady: drop memReq, set timeoutError (sticky until
//     reset), go to RESP.
//   - The RESP success pulse returns data 32'h00000000 (ifData on IF; dmRData on data read).
//  ARB_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely.
//   - timeoutError is constant 0.
// TESTING
//  1. Reset: rst=0 during a BUSY_D access -> memReq=0 the same cycle. All outputs at reset values;
//     IDLE after release.
//  2. Single fetch, zero-wait memory: ifReq, ifAddr=0x00000040 at edge 0; memReady=1 in the first
//     memReq cycle, memRData=0x00A00093 -> ifSuccess high cycle 2, ifData=0x00A00093, memWrite=0.
//  3. Contention: dmReq + ifReq held high, each access 2 wait states, DATA_STREAK_MAX=4
//     -> grant order D,D,D,D,I,D,D,D,D,I; no double-success cycles.
//  4. Data write: dmWrite=1, dmAddr=0x1000, dmWData=0xDEADBEEF, dmByteEnable=4'b0011
//     -> mem* match exactly while memReq high; dmSuccess pulses once; dmRData unchanged.
//  5. Wait states: memReady held low for 7 cycles -> mem* outputs stable for all 8 memReq cycles;
//     success exactly 1 cycle after memReady.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, memReady never asserted -> memReq drops after 16 cycles;
//     dmSuccess pulses with dmRData=0; timeoutError=1 and stays 1 until reset.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data requesters.
// Data has priority, bounded by a streak limit. Define ARB_TIMEOUT_EN to enable the BUSY watchdog.
module memory_port_arbiter #(
   parameter int DATA_STREAK_MAX = 4
`ifdef ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifReq,
   input  logic [31:0] ifAddr,
   output logic        ifSuccess,
   output logic [31:0] ifData,
   input  logic        dmReq,
   input  logic        dmWrite,
   input  logic [31:0] dmAddr,
   input  logic [31:0] dmWData,
   input  logic [3:0]  dmByteEnable,
   output logic        dmSuccess,
   output logic [31:0] dmRData,
   output logic        memReq,
   output logic        memWrite,
   output logic [31:0] memAddr,
   output logic [31:0] memWData,
   output logic [3:0]  memByteEnable,
   input  logic        memReady,
   input  logic [31:0] memRData,
   output logic        timeoutError
);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

   localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);

   state_t              state;
   logic [STREAK_W-1:0] streak;
   logic                streakFull;
   logic                grantData;
   logic                timedOut;
   logic                accessDone;
   logic [31:0]         returnData;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      streakFull = (streak == STREAK_LIMIT);
      grantData  = dmReq && !(ifReq && streakFull);
      accessDone = memReady || timedOut;
      returnData = memReady ? memRData : 32'h0000_0000;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] busyCount;

   assign timedOut = (busyCount == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busyCount    <= '0;
         timeoutError <= 1'b0;
      end else begin
         if (state == BUSY_D || state == BUSY_I) begin
            busyCount <= busyCount + TO_W'(1);
            if (timedOut && !memReady)
               timeoutError <= 1'b1;
         end else begin
            busyCount <= '0;
         end
      end
   end
`else
   assign timedOut     = 1'b0;
   assign timeoutError = 1'b0;
`endif

   // NOTE: asynchronous active-low reset; memReq drops the instant rst falls, abandoning any access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         streak        <= '0;
         memReq        <= 1'b0;
         memWrite      <= 1'b0;
         memAddr       <= '0;
         memWData      <= '0;
         memByteEnable <= '0;
         ifSuccess     <= 1'b0;
         dmSuccess     <= 1'b0;
         ifData        <= '0;
         dmRData       <= '0;
      end else begin
         // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
         ifSuccess <= 1'b0;
         dmSuccess <= 1'b0;
         case (state)
            IDLE: begin
               if (grantData) begin
                  state         <= BUSY_D;
                  memReq        <= 1'b1;
                  memWrite      <= dmWrite;
                  memAddr       <= dmAddr;
                  memWData      <= dmWData;
                  memByteEnable <= dmByteEnable;
                  if (!ifReq)
                     streak <= '0;
                  else if (!streakFull)
                     streak <= streak + STREAK_W'(1);
               end else if (ifReq) begin
                  state    <= BUSY_I;
                  memReq   <= 1'b1;
                  memWrite <= 1'b0;
                  memAddr  <= ifAddr;
                  streak   <= '0;
               end
            end
            BUSY_D: begin
               if (accessDone) begin
                  state     <= RESP;
                  memReq    <= 1'b0;
                  memWrite  <= 1'b0;
                  dmSuccess <= 1'b1;
                  if (!memWrite)
                     dmRData <= returnData;
               end
            end
            BUSY_I: begin
               if (accessDone) begin
                  state     <= RESP;
                  memReq    <= 1'b0;
                  ifSuccess <= 1'b1;
                  ifData    <= returnData;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter against a transaction-level reference model.
// Define ARB_TIMEOUT_EN to also exercise the watchdog with a 16-cycle limit.
module tb_memory_port_arbiter;

   localparam int STREAK = 4;
`ifdef ARB_TIMEOUT_EN
   localparam int TIMEOUT = 16;
`endif
   localparam logic [7:0] CH_D = "D";
   localparam logic [7:0] CH_I = "I";

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifReq = 1'b0;
   logic [31:0] ifAddr = '0;
   logic        ifSuccess;
   logic [31:0] ifData;
   logic        dmReq = 1'b0;
   logic        dmWrite = 1'b0;
   logic [31:0] dmAddr = '0;
   logic [31:0] dmWData = '0;
   logic [3:0]  dmByteEnable = '0;
   logic        dmSuccess;
   logic [31:0] dmRData;
   logic        memReq;
   logic        memWrite;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic [3:0]  memByteEnable;
   logic        memReady = 1'b0;
   logic [31:0] memRData = '0;
   logic        timeoutError;

   always #5 clk = ~clk;

   memory_port_arbiter #(
      .DATA_STREAK_MAX(STREAK)
`ifdef ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TIMEOUT)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifSuccess(ifSuccess), .ifData(ifData),
      .dmReq(dmReq), .dmWrite(dmWrite), .dmAddr(dmAddr), .dmWData(dmWData),
      .dmByteEnable(dmByteEnable), .dmSuccess(dmSuccess), .dmRData(dmRData),
      .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
      .memByteEnable(memByteEnable), .memReady(memReady), .memRData(memRData),
      .timeoutError(timeoutError)
   );

   int nChecks = 0;
   int nPass = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed === expected) nPass++;
      else $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   // Reference model: the access in flight, pending completions and the user-visible registers.
   bit          mOut, mIsData, mWrite, mIfSucc, mDmSucc, mTimeout;
   logic [31:0] mAddr, mWData, mIfData, mDmRData;
   logic [3:0]  mBe;
   int          mStreak, mBusy;

   // Stimulus policy
   bit          ifPend, dmPend, dropEn, dmReadOnly, useFixedRData, logGrants, prevMemReq;
   int          ifRate, dmRate, readyRate, fixedWait;
   logic [31:0] fixedRData;
   logic [7:0]  grantLog[$];

   task automatic completeAccess(input logic [31:0] data);
      mOut = 1'b0;
      if (mIsData) begin
         mDmSucc = 1'b1;
         if (!mWrite) mDmRData = data;
      end else begin
         mIfSucc  = 1'b1;
         mIfData  = data;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check("memReq", 32'(memReq), 32'(mOut));
      if (mOut) begin
         check("memAddr", memAddr, mAddr);
         check("memWrite", 32'(memWrite), 32'(mWrite));
         if (mWrite) begin
            check("memWData", memWData, mWData);
            check("memByteEnable", 32'(memByteEnable), 32'(mBe));
         end
      end
      check("ifSuccess", 32'(ifSuccess), 32'(mIfSucc));
      check("dmSuccess", 32'(dmSuccess), 32'(mDmSucc));
      check("oneSuccess", 32'(ifSuccess && dmSuccess), 32'(0));
      check("ifData", ifData, mIfData);
      check("dmRData", dmRData, mDmRData);
      check("timeoutError", 32'(timeoutError), 32'(mTimeout));
      if (logGrants && memReq && !prevMemReq) grantLog.push_back((memAddr == dmAddr) ? CH_D : CH_I);
      prevMemReq = memReq;

      // Requesters: finish on success, occasionally abandon an in-flight access, issue new work.
      if (mIfSucc) ifPend = 1'b0;
      if (mDmSucc) dmPend = 1'b0;
      if (dropEn && mOut && ifPend && !mIsData && $urandom_range(19) == 0) ifPend = 1'b0;
      if (dropEn && mOut && dmPend && mIsData && $urandom_range(19) == 0) dmPend = 1'b0;
      if (!ifPend && !(mOut && !mIsData) && $urandom_range(99) < ifRate) begin
         ifPend = 1'b1;
         ifAddr = $urandom;
      end
      if (!dmPend && !(mOut && mIsData) && $urandom_range(99) < dmRate) begin
         dmPend       = 1'b1;
         dmWrite      = dmReadOnly ? 1'b0 : 1'($urandom_range(1));
         dmAddr       = $urandom;
         dmWData      = $urandom;
         dmByteEnable = 4'($urandom_range(15));
      end
      ifReq    = ifPend;
      dmReq    = dmPend;
      memReady = (fixedWait >= 0) ? (mOut && mBusy == fixedWait) : ($urandom_range(99) < readyRate);
      memRData = useFixedRData ? fixedRData : $urandom;

      // Model: what the coming clock edge does with these inputs.
      if (mIfSucc || mDmSucc) begin
         mIfSucc = 1'b0;
         mDmSucc = 1'b0;
      end else if (mOut) begin
         if (memReady) completeAccess(memRData);
`ifdef ARB_TIMEOUT_EN
         else if (mBusy + 1 == TIMEOUT) begin
            completeAccess(32'h0000_0000);
            mTimeout = 1'b1;
         end
`endif
         else mBusy++;
      end else if (dmReq && !(ifReq && mStreak == STREAK)) begin
         mOut = 1'b1; mBusy = 0; mIsData = 1'b1;
         mWrite = dmWrite; mAddr = dmAddr; mWData = dmWData; mBe = dmByteEnable;
         mStreak = ifReq ? ((mStreak < STREAK) ? mStreak + 1 : STREAK) : 0;
      end else if (ifReq) begin
         mOut = 1'b1; mBusy = 0; mIsData = 1'b0; mWrite = 1'b0; mAddr = ifAddr;
         mStreak = 0;
      end
   endtask

   task automatic setPolicy(input int ifR, input int dmR, input int readyR, input int fw, input bit drop);
      ifRate = ifR; dmRate = dmR; readyRate = readyR; fixedWait = fw; dropEn = drop;
      dmReadOnly = 1'b0; useFixedRData = 1'b0; logGrants = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstMemReqAsync", 32'(memReq), 32'(0));
      check("rstIfSuccess", 32'(ifSuccess), 32'(0));
      check("rstDmSuccess", 32'(dmSuccess), 32'(0));
      ifReq = 1'b0; dmReq = 1'b0; dmWrite = 1'b0; memReady = 1'b0;
      ifPend = 1'b0; dmPend = 1'b0; prevMemReq = 1'b0;
      mOut = 1'b0; mIfSucc = 1'b0; mDmSucc = 1'b0; mTimeout = 1'b0;
      mIfData = '0; mDmRData = '0; mStreak = 0; mBusy = 0;
      @(negedge clk);
      check("rstMemWrite", 32'(memWrite), 32'(0));
      check("rstMemAddr", memAddr, 32'(0));
      check("rstMemWData", memWData, 32'(0));
      check("rstMemByteEnable", 32'(memByteEnable), 32'(0));
      check("rstIfData", ifData, 32'(0));
      check("rstDmRData", dmRData, 32'(0));
      check("rstTimeoutError", 32'(timeoutError), 32'(0));
      rst = 1'b1;
   endtask

   initial begin
      string expOrder;
      expOrder = "DDDDIDDDDI";
      setPolicy(0, 0, 0, -1, 1'b0);
      doReset();

      // Single zero-wait fetch of a known instruction word.
      setPolicy(0, 0, 0, 0, 1'b0);
      useFixedRData = 1'b1;
      fixedRData    = 32'h00A0_0093;
      ifPend = 1'b1;
      ifAddr = 32'h0000_0040;
      for (int i = 0; i < 3; i++) step();
      check("fetchData", ifData, 32'h00A0_0093);
      check("fetchSuccess", 32'(ifSuccess), 32'(1));
      step();

      // Mixed random traffic with wait states and abandoned requests, then back-to-back zero-wait.
      setPolicy(40, 40, 35, -1, 1'b1);
      for (int i = 0; i < 1500; i++) step();
      setPolicy(60, 60, 100, -1, 1'b0);
      for (int i = 0; i < 300; i++) step();

      // Asynchronous reset in the middle of a data access.
      setPolicy(0, 0, 0, -1, 1'b0);
      for (int i = 0; i < 10; i++) step();
      setPolicy(0, 100, 0, -1, 1'b0);
      for (int i = 0; i < 20 && !(mOut && mIsData); i++) step();
      step();
      check("busyBeforeReset", 32'(memReq), 32'(1));
      doReset();

      // Contention: both requesters always asking, two wait states per access.
      setPolicy(100, 100, 0, 2, 1'b0);
      logGrants = 1'b1;
      grantLog.delete();
      for (int i = 0; i < 55; i++) step();
      check("grantCount", 32'(grantLog.size() >= 10), 32'(1));
      for (int i = 0; i < 10 && i < grantLog.size(); i++)
         check("grantOrder", 32'(grantLog[i]), 32'(expOrder[i]));

`ifdef ARB_TIMEOUT_EN
      // Unresponsive memory: data reads time out and the error flag sticks.
      doReset();
      setPolicy(0, 100, 0, -1, 1'b0);
      dmReadOnly = 1'b1;
      for (int i = 0; i < 45; i++) step();
      check("timeoutSticky", 32'(timeoutError), 32'(1));
      check("timeoutData", dmRData, 32'(0));
      setPolicy(50, 50, 50, -1, 1'b0);
      for (int i = 0; i < 100; i++) step();
      check("timeoutStillSet", 32'(timeoutError), 32'(1));
      doReset();
`endif

      setPolicy(0, 0, 0, -1, 1'b0);
      for (int i = 0; i < 8; i++) step();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
